sirv_pwm16_deadtime: RTL and testbench

//  Downstream stage of the pwm16 peripheral. Takes each single-ended PWM output
//  (io_gpio_0..3) and drives a complementary high-side/low-side pair.

---
 rtl/sirv_pwm16_deadtime_pkg.sv | 28 ++
 rtl/sirv_pwm16_deadtime_if.sv | 21 ++
 rtl/sirv_pwm16_deadtime_chnl.sv | 85 ++++++++
 rtl/sirv_pwm16_deadtime.sv | 108 ++++++++++
 tb/tb_sirv_pwm16_deadtime.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sirv_pwm16_deadtime_pkg.sv
// Shared definitions for the pwm16 dead-time stage: channel FSM states,
// register offsets and CTRL/STAT field positions.
package sirv_pwm16_deadtime_pkg;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_DT_R = 3'd1,
    ST_HI   = 3'd2,
    ST_DT_F = 3'd3,
    ST_LO   = 3'd4
  } chnl_state_e;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DT   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  localparam int CTRL_EN_LSB  = 0;
  localparam int CTRL_POL_LSB = 4;
  localparam int STAT_HI_LSB  = 0;
  localparam int STAT_LO_LSB  = 4;

  // Only the word offset inside the 16-byte window is decoded.
  function automatic logic [1:0] reg_sel(input logic [31:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/sirv_pwm16_deadtime_if.sv
// ICB command/response bundle used by the dead-time stage's config port.
interface sirv_pwm16_deadtime_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sirv_pwm16_deadtime_chnl.sv
// One complementary output channel: dead-time FSM plus its down-counter.
//   state | meaning
//   OFF   | disabled, both sides off
//   DT_R  | dead time before high side turns on
//   HI    | high side on
//   DT_F  | dead time before low side turns on
//   LO    | low side on
module sirv_pwm16_deadtime_chnl
  import sirv_pwm16_deadtime_pkg::*;
#(
  parameter int DTW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           pol_i,
  input  logic           pwm_i,
  input  logic [DTW-1:0] dt_i,
  output logic           hi_st_o,
  output logic           lo_st_o,
  output logic           hi_o,
  output logic           lo_o
);

  chnl_state_e    state_q, state_d;
  logic [DTW-1:0] cnt_q, cnt_d;
  logic           cnt_tc;

  assign cnt_tc = (cnt_q <= DTW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          cnt_d   = dt_i;
          state_d = pwm_i ? ST_DT_R : ST_DT_F;
        end
        // A pulse that ends inside the dead time is swallowed.
        ST_DT_R: begin
          if (!pwm_i)      state_d = ST_LO;
          else if (cnt_tc) state_d = ST_HI;
          else             cnt_d   = cnt_q - DTW'(1);
        end
        ST_HI: begin
          if (!pwm_i) begin
            cnt_d   = dt_i;
            state_d = ST_DT_F;
          end
        end
        ST_DT_F: begin
          if (pwm_i)       state_d = ST_HI;
          else if (cnt_tc) state_d = ST_LO;
          else             cnt_d   = cnt_q - DTW'(1);
        end
        ST_LO: begin
          if (pwm_i) begin
            cnt_d   = dt_i;
            state_d = ST_DT_R;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign hi_st_o = (state_q == ST_HI);
  assign lo_st_o = (state_q == ST_LO);
  assign hi_o    = hi_st_o ^ pol_i;
  assign lo_o    = lo_st_o ^ pol_i;

endmodule

// File: rtl/sirv_pwm16_deadtime.sv
// Complementary dead-time stage after pwm16: ICB config slave, CTRL/DT
// registers and one dead-time channel per pwm16 comparator output.
module sirv_pwm16_deadtime
  import sirv_pwm16_deadtime_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DTW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sirv_pwm16_deadtime_if.slave i_icb,
  input  logic [NCH-1:0]      pwm_in,
  output logic [NCH-1:0]      pwm_hi_o,
  output logic [NCH-1:0]      pwm_lo_o
);

  localparam int CW = CTRL_POL_LSB + NCH;

  logic [CW-1:0]  ctrl_q, ctrl_d;
  logic [DTW-1:0] dt_q, dt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rdata_q, rdata_d;

  logic           cmd_ready;
  logic           cmd_hsk;
  logic [1:0]     sel;
  logic [31:0]    stat_w;
  logic [31:0]    rd_mux;
  logic [NCH-1:0] hi_st, lo_st;
  logic           unused_bits;

  assign cmd_ready = ~rsp_valid_q | i_icb.rsp_ready;
  assign cmd_hsk   = i_icb.cmd_valid & cmd_ready;
  assign sel       = reg_sel(i_icb.cmd_addr);

  assign i_icb.cmd_ready = cmd_ready;
  assign i_icb.rsp_valid = rsp_valid_q;
  assign i_icb.rsp_rdata = rdata_q;

  assign unused_bits = ^{i_icb.cmd_addr[31:4], i_icb.cmd_addr[1:0], i_icb.cmd_wdata};

  always_comb begin
    stat_w = '0;
    stat_w[STAT_HI_LSB +: NCH] = hi_st;
    stat_w[STAT_LO_LSB +: NCH] = lo_st;
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_CTRL: rd_mux = 32'(ctrl_q);
      REG_DT:   rd_mux = 32'(dt_q);
      REG_STAT: rd_mux = stat_w;
      REG_RSVD: rd_mux = '0;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    dt_d        = dt_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    if (cmd_hsk) begin
      rsp_valid_d = 1'b1;
      rdata_d     = i_icb.cmd_read ? rd_mux : '0;
      if (!i_icb.cmd_read) begin
        case (sel)
          REG_CTRL: ctrl_d = i_icb.cmd_wdata[CW-1:0];
          REG_DT:   dt_d   = i_icb.cmd_wdata[DTW-1:0];
          default:  ;
        endcase
      end
    end else if (i_icb.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      dt_q        <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      dt_q        <= dt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chnl
    sirv_pwm16_deadtime_chnl #(.DTW(DTW)) u_chnl (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (ctrl_q[CTRL_EN_LSB + g]),
      .pol_i   (ctrl_q[CTRL_POL_LSB + g]),
      .pwm_i   (pwm_in[g]),
      .dt_i    (dt_q),
      .hi_st_o (hi_st[g]),
      .lo_st_o (lo_st[g]),
      .hi_o    (pwm_hi_o[g]),
      .lo_o    (pwm_lo_o[g])
    );
  end

endmodule

// File: tb/tb_sirv_pwm16_deadtime.sv
// Directed self-checking bench for sirv_pwm16_deadtime.
module tb_sirv_pwm16_deadtime;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pwm_in;
  logic [3:0] pwm_hi_o;
  logic [3:0] pwm_lo_o;
  int         checks = 0;
  int         errors = 0;

  sirv_pwm16_deadtime_if icb ();

  sirv_pwm16_deadtime #(.NCH(4), .DTW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_icb    (icb),
    .pwm_in   (pwm_in),
    .pwm_hi_o (pwm_hi_o),
    .pwm_lo_o (pwm_lo_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic icb_write(input logic [31:0] addr, input logic [31:0] data);
    icb.cmd_valid = 1'b1;
    icb.cmd_read  = 1'b0;
    icb.cmd_addr  = addr;
    icb.cmd_wdata = data;
    tick();
    icb.cmd_valid = 1'b0;
    tick();
  endtask

  task automatic icb_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    icb.cmd_valid = 1'b1;
    icb.cmd_read  = 1'b1;
    icb.cmd_addr  = addr;
    icb.cmd_wdata = 32'h0;
    tick();
    icb.cmd_valid = 1'b0;
    chk({tag, "_vld"}, 32'(icb.rsp_valid), 32'h1);
    chk(tag, icb.rsp_rdata, exp);
    tick();
  endtask

  initial begin
    logic [3:0] sq_in, sq_hi, sq_lo;
    sq_in = 4'b0011;
    sq_hi = 4'b0010;
    sq_lo = 4'b1000;

    // 1: reset with all inputs high
    rst_n         = 1'b0;
    pwm_in        = 4'hF;
    icb.cmd_valid = 1'b0;
    icb.cmd_read  = 1'b0;
    icb.cmd_addr  = 32'h0;
    icb.cmd_wdata = 32'h0;
    icb.rsp_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_hi", 32'(pwm_hi_o), 32'h0);
    chk("rst_lo", 32'(pwm_lo_o), 32'h0);
    chk("rst_rsp_valid", 32'(icb.rsp_valid), 32'h0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_hi", 32'(pwm_hi_o), 32'h0);
    icb_read("rst_stat", 32'h8, 32'h0);
    icb_read("rst_ctrl", 32'h0, 32'h0);
    icb_read("rst_dt",   32'h4, 32'h0);

    // 2: DT=3, ch0 rising edge
    pwm_in = 4'h0;
    icb_write(32'h4, 32'h3);
    icb_write(32'h0, 32'h1);
    tick(); tick(); tick(); tick();
    chk("t2_lo_pre", 32'(pwm_lo_o), 32'h1);
    chk("t2_hi_pre", 32'(pwm_hi_o), 32'h0);
    pwm_in[0] = 1'b1;
    tick();
    chk("t2_lo_edge", 32'(pwm_lo_o), 32'h0);
    chk("t2_hi_dt1", 32'(pwm_hi_o), 32'h0);
    tick();
    chk("t2_hi_dt2", 32'(pwm_hi_o), 32'h0);
    tick();
    chk("t2_hi_dt3", 32'(pwm_hi_o), 32'h0);
    chk("t2_lo_dt3", 32'(pwm_lo_o), 32'h0);
    tick();
    chk("t2_hi_on", 32'(pwm_hi_o), 32'h1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("t2_hi_hold", 32'(pwm_hi_o), 32'h1);
      chk("t2_lo_hold", 32'(pwm_lo_o), 32'h0);
    end
    icb_read("t2_stat", 32'h8, 32'h01);

    // 3: DT=5 loaded on next fall, then a 1-cycle pulse from LO
    icb_write(32'h4, 32'h5);
    chk("t3_hi_still", 32'(pwm_hi_o), 32'h1);
    pwm_in[0] = 1'b0;
    tick();
    chk("t3_fall_hi", 32'(pwm_hi_o), 32'h0);
    chk("t3_fall_lo", 32'(pwm_lo_o), 32'h0);
    tick(); tick(); tick(); tick();
    chk("t3_dt5_lo", 32'(pwm_lo_o), 32'h0);
    tick();
    chk("t3_lo_on", 32'(pwm_lo_o), 32'h1);
    pwm_in[0] = 1'b1;
    tick();
    pwm_in[0] = 1'b0;
    chk("t3_pulse_hi", 32'(pwm_hi_o), 32'h0);
    chk("t3_pulse_lo", 32'(pwm_lo_o), 32'h0);
    tick();
    chk("t3_back_lo", 32'(pwm_lo_o), 32'h1);
    chk("t3_back_hi", 32'(pwm_hi_o), 32'h0);
    tick();
    chk("t3_stay_hi", 32'(pwm_hi_o), 32'h0);

    // 4: DT=0, ch1 square wave period 4
    icb_write(32'h4, 32'h0);
    icb_write(32'h0, 32'h3);
    tick();
    chk("t4_lo_init", 32'(pwm_lo_o), 32'h3);
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 4; s++) begin
        pwm_in[1] = sq_in[s];
        tick();
        chk("t4_hi1", 32'(pwm_hi_o[1]), 32'(sq_hi[s]));
        chk("t4_lo1", 32'(pwm_lo_o[1]), 32'(sq_lo[s]));
        chk("t4_overlap", 32'(pwm_hi_o & pwm_lo_o), 32'h0);
      end
    end

    // 5: polarity on ch0 in HI, then disable
    pwm_in = 4'b0001;
    tick(); tick();
    chk("t5_hi_pre", 32'(pwm_hi_o), 32'h1);
    chk("t5_lo_pre", 32'(pwm_lo_o), 32'h2);
    icb_write(32'h0, 32'h11);
    chk("t5_pol_hi", 32'(pwm_hi_o), 32'h0);
    chk("t5_pol_lo", 32'(pwm_lo_o), 32'h1);
    icb_write(32'h0, 32'h10);
    chk("t5_off_hi", 32'(pwm_hi_o), 32'h1);
    chk("t5_off_lo", 32'(pwm_lo_o), 32'h1);
    icb_read("t5_stat", 32'h8, 32'h0);

    // 6: register decode and response back-pressure
    icb_write(32'h4, 32'hA5);
    icb_read("t6_dt",    32'h4,  32'hA5);
    icb_read("t6_alias", 32'h14, 32'hA5);
    icb_read("t6_rsvd",  32'hC,  32'h0);
    icb_write(32'hC, 32'hFFFF_FFFF);
    icb_read("t6_ctrl_keep", 32'h0, 32'h10);
    icb_read("t6_dt_keep",   32'h4, 32'hA5);

    icb.rsp_ready = 1'b0;
    icb.cmd_valid = 1'b1;
    icb.cmd_read  = 1'b0;
    icb.cmd_addr  = 32'h0;
    icb.cmd_wdata = 32'h0;
    #1;
    chk("t6_rdy_idle", 32'(icb.cmd_ready), 32'h1);
    tick();
    chk("t6_wr_rsp", 32'(icb.rsp_valid), 32'h1);
    chk("t6_rdy_stall", 32'(icb.cmd_ready), 32'h0);
    icb.cmd_read = 1'b1;
    icb.cmd_addr = 32'h4;
    tick();
    chk("t6_hold_vld", 32'(icb.rsp_valid), 32'h1);
    chk("t6_hold_rdy", 32'(icb.cmd_ready), 32'h0);
    chk("t6_hold_rdata", icb.rsp_rdata, 32'h0);
    chk("t6_wr_effect", 32'(pwm_hi_o), 32'h0);
    tick();
    chk("t6_hold2_rdy", 32'(icb.cmd_ready), 32'h0);
    icb.rsp_ready = 1'b1;
    #1;
    chk("t6_rdy_release", 32'(icb.cmd_ready), 32'h1);
    tick();
    icb.cmd_valid = 1'b0;
    chk("t6_rd_vld", 32'(icb.rsp_valid), 32'h1);
    chk("t6_rd_data", icb.rsp_rdata, 32'hA5);
    tick();
    chk("t6_rsp_done", 32'(icb.rsp_valid), 32'h0);

    // reset asserted mid-operation
    icb_write(32'h4, 32'h0);
    pwm_in = 4'b0001;
    icb_write(32'h0, 32'h1);
    tick(); tick();
    chk("t7_hi_pre", 32'(pwm_hi_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_hi", 32'(pwm_hi_o), 32'h0);
    chk("t7_rst_lo", 32'(pwm_lo_o), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    icb_read("t7_ctrl", 32'h0, 32'h0);
    icb_read("t7_stat", 32'h8, 32'h0);
    chk("t7_hi_post", 32'(pwm_hi_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
